fetch_stall_unit: RTL and testbench
===================================

Name: fetch_stall_unit

Overview:
- Fetch stage plus IF/ID pipeline register for the 16-bit five-stage pipeline.
- Owns the PC and drives the instruction-memory address.
- Consumes the hazard unit's active-low sendNOP: on a stall it freezes the PC and IF/ID, and injects a NOP bubble toward ID/EX.
- Also handles branch redirect/flush and HALT, and keeps a saturating stall counter for performance debug.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INST, 16'h0800, encoding injected as a bubble
CNT_W, 16, width of stall counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
sendNOP  input  1  from hazard unit; 0 = stall/insert bubble, 1 = proceed
branch_taken  input  1  resolved branch/jump redirect this cycle
branch_target  input  16  redirect PC
imem_inst  input  16  instruction at imem_addr (combinational read)
imem_addr  output  16  current PC (= pc register)
ifid_inst  output  16  registered IF/ID instruction
ifid_pc2  output  16  registered PC+2 of ifid_inst
dec_inst  output  16  instruction forwarded to decode/ID-EX: sendNOP ? ifid_inst : NOP_INST
dec_nop_n  output  1  0 when dec_inst is a bubble (ifid_nop_n & sendNOP)
halted  output  1  registered, HALT fetched and PC frozen
align_err  output  1  registered one-cycle pulse, branch_target[0]==1 on redirect
stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values (rst_n==0 at an edge):
  - pc = RESET_PC; ifid_inst = NOP_INST; ifid_pc2 = 0; internal ifid_nop_n = 0.
  - halted = 0; align_err = 0; stall_cnt = 0.
  - Reset mid-stall or mid-halt discards all state.
- Per-edge priority: reset > flush > stall > halt > normal.
- Flush (branch_taken==1), regardless of sendNOP:
  - pc <= {branch_target[15:1],1'b0}.
  - ifid_inst <= NOP_INST; ifid_nop_n <= 0; halted <= 0.
  - align_err <= branch_target[0]; stall_cnt does not increment.
- Stall (sendNOP==0, no flush):
  - pc, ifid_inst, ifid_pc2 and ifid_nop_n hold.
  - stall_cnt <= stall_cnt+1, saturating at all-ones.
  - Combinationally, dec_inst = NOP_INST and dec_nop_n = 0 in the same cycle.
- Halted (halted==1, no flush, no stall):
  - pc holds; ifid_inst <= NOP_INST; ifid_nop_n <= 0.
- Normal:
  - pc <= pc+2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
  - ifid_inst <= imem_inst; ifid_pc2 <= pc+2; ifid_nop_n <= 1.
  - If imem_inst[15:11]==5'b00000 (HALT): HALT is still loaded into IF/ID, halted <= 1, and pc <= pc (no increment).
- align_err clears to 0 on any edge without a flush.
- Latency:
  - imem_inst captured at edge N appears on ifid_inst after edge N.
  - dec_inst tracks ifid_inst with zero cycles of extra latency when sendNOP==1.
- dec_nop_n uses the active-low NOP-flag convention of the downstream stages: 1 = real instruction.
- A stall with ifid_nop_n==0 still counts as a stall cycle.
- Simultaneous HALT fetch and stall: stall wins; halted stays 0 and pc holds.

Test Plan:
- Reset, imem returns 16'h4000 every fetch, sendNOP=1 -> imem_addr 0,2,4,6 on consecutive cycles; ifid_pc2 = 2,4,6; dec_nop_n=1 from the 2nd cycle after reset release.
- Hold sendNOP=0 for 3 cycles with ifid_inst=16'hD8A0 -> pc and ifid_inst frozen; dec_inst=16'h0800 and dec_nop_n=0 during those cycles; stall_cnt=3; fetch resumes with pc+2 afterwards.
- branch_taken=1, target 16'h0040, concurrent with sendNOP=0 -> next imem_addr=16'h0040; ifid_inst=16'h0800; stall_cnt unchanged; align_err=0.
- branch_target=16'h0041 with branch_taken -> pc=16'h0040, align_err=1 for exactly one cycle.
- imem returns 16'h0000 at pc=16'h0010 -> ifid_inst=16'h0000, halted=1, pc stays 16'h0010, following ifid_inst=16'h0800; a later branch_taken to 16'h0020 clears halted and fetch resumes at 16'h0020.
- Preload pc=16'hFFFE via branch, run normal -> next pc=16'h0000. Force stall_cnt to 16'hFFFF, then stall -> it stays at 16'hFFFF.
- Pulse rst_n=0 during a stall -> all outputs return to their reset values on that edge.

Source files
------------

// File: rtl/fetch_stall_unit.sv
// Fetch stage plus IF/ID pipeline register.
// Owns the PC, reacts to the hazard unit's active-low sendNOP (freeze and
// bubble), branch redirect/flush and HALT, and counts stall cycles.
module fetch_stall_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sendNOP,
    input  logic             branch_taken,
    input  logic [15:0]      branch_target,
    input  logic [15:0]      imem_inst,
    output logic [15:0]      imem_addr,
    output logic [15:0]      ifid_inst,
    output logic [15:0]      ifid_pc2,
    output logic [15:0]      dec_inst,
    output logic             dec_nop_n,
    output logic             halted,
    output logic             align_err,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [15:0]      pc_q, pc_d;
    logic [15:0]      ifid_inst_q, ifid_inst_d;
    logic [15:0]      ifid_pc2_q, ifid_pc2_d;
    logic             ifid_nop_n_q, ifid_nop_n_d;
    logic             halted_q, halted_d;
    logic             align_err_q, align_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [15:0]      pc_plus2;
    logic             fetched_halt;
    logic             cnt_full;

    assign pc_plus2     = pc_q + 16'd2;
    assign fetched_halt = (imem_inst[15:11] == 5'b00000);
    assign cnt_full     = (stall_cnt_q == {CNT_W{1'b1}});

    // Next-state selection: flush > stall > halt > normal fetch.
    always_comb begin
        pc_d         = pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc2_d   = ifid_pc2_q;
        ifid_nop_n_d = ifid_nop_n_q;
        halted_d     = halted_q;
        align_err_d  = 1'b0;
        stall_cnt_d  = stall_cnt_q;

        if (branch_taken) begin
            // Redirect: the low bit is dropped and reported as misalignment.
            pc_d         = {branch_target[15:1], 1'b0};
            ifid_inst_d  = NOP_INST;
            ifid_nop_n_d = 1'b0;
            halted_d     = 1'b0;
            align_err_d  = branch_target[0];
        end else if (!sendNOP) begin
            // Freeze PC and IF/ID; only the debug counter moves.
            if (!cnt_full) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (halted_q) begin
            ifid_inst_d  = NOP_INST;
            ifid_nop_n_d = 1'b0;
        end else begin
            ifid_inst_d  = imem_inst;
            ifid_pc2_d   = pc_plus2;
            ifid_nop_n_d = 1'b1;
            if (fetched_halt) begin
                // HALT itself still goes down the pipe; PC stops on it.
                halted_d = 1'b1;
            end else begin
                pc_d = pc_plus2;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            ifid_inst_q  <= NOP_INST;
            ifid_pc2_q   <= 16'h0000;
            ifid_nop_n_q <= 1'b0;
            halted_q     <= 1'b0;
            align_err_q  <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc2_q   <= ifid_pc2_d;
            ifid_nop_n_q <= ifid_nop_n_d;
            halted_q     <= halted_d;
            align_err_q  <= align_err_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign imem_addr = pc_q;
    assign ifid_inst = ifid_inst_q;
    assign ifid_pc2  = ifid_pc2_q;
    assign halted    = halted_q;
    assign align_err = align_err_q;
    assign stall_cnt = stall_cnt_q;

    // A stall turns the decode-side instruction into a bubble immediately.
    assign dec_inst  = sendNOP ? ifid_inst_q : NOP_INST;
    assign dec_nop_n = ifid_nop_n_q & sendNOP;

endmodule

// File: tb/tb_fetch_stall_unit.sv
// Self-checking bench for fetch_stall_unit using a queue of expected values.
module tb_fetch_stall_unit;

    logic        clk;
    logic        rst_n;
    logic        send_nop;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_word;
    logic [15:0] halt_addr;
    logic        halt_en;
    logic [15:0] imem_inst;

    logic [15:0] imem_addr, ifid_inst, ifid_pc2, dec_inst, stall_cnt;
    logic        dec_nop_n, halted, align_err;

    logic [15:0] s_imem_addr, s_ifid_inst, s_ifid_pc2, s_dec_inst;
    logic        s_dec_nop_n, s_halted, s_align_err;
    logic [2:0]  sat_cnt;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] obs;
    int          vectors;
    int          miscompares;
    int          exp_cnt;

    // Simple instruction memory: a constant word, with an optional HALT slot.
    assign imem_inst = (halt_en && imem_addr == halt_addr) ? 16'h0000 : imem_word;

    fetch_stall_unit dut (
        .clk(clk), .rst_n(rst_n), .sendNOP(send_nop),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_inst(imem_inst), .imem_addr(imem_addr), .ifid_inst(ifid_inst),
        .ifid_pc2(ifid_pc2), .dec_inst(dec_inst), .dec_nop_n(dec_nop_n),
        .halted(halted), .align_err(align_err), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a few cycles.
    fetch_stall_unit #(.CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .sendNOP(send_nop),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_inst(imem_inst), .imem_addr(s_imem_addr), .ifid_inst(s_ifid_inst),
        .ifid_pc2(s_ifid_pc2), .dec_inst(s_dec_inst), .dec_nop_n(s_dec_nop_n),
        .halted(s_halted), .align_err(s_align_err), .stall_cnt(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string n, input logic [15:0] v);
        exp_t x;
        x.name = n;
        x.val  = v;
        sb.push_back(x);
    endtask

    function automatic logic [15:0] observe(input string n);
        case (n)
            "imem_addr": return imem_addr;
            "ifid_inst": return ifid_inst;
            "ifid_pc2":  return ifid_pc2;
            "dec_inst":  return dec_inst;
            "dec_nop_n": return {15'd0, dec_nop_n};
            "halted":    return {15'd0, halted};
            "align_err": return {15'd0, align_err};
            "stall_cnt": return stall_cnt;
            "sat_cnt":   return {13'd0, sat_cnt};
            default:     return 16'hxxxx;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; send_nop = 1'b1; branch_taken = 1'b0; branch_target = 16'h0000;
        imem_word = 16'h4000; halt_en = 1'b0; halt_addr = 16'h0000;
        tick();
        sb_push("imem_addr", 16'h0000); sb_push("ifid_inst", 16'h0800);
        sb_push("ifid_pc2", 16'h0000);  sb_push("dec_inst", 16'h0800);
        sb_push("dec_nop_n", 16'h0000); sb_push("halted", 16'h0000);
        sb_push("align_err", 16'h0000); sb_push("stall_cnt", 16'h0000);
        sb_push("sat_cnt", 16'h0000);
        tick();
        while (sb.size() != 0) begin
            e = sb.pop_front(); obs = observe(e.name); vectors++;
            if (obs !== e.val) begin
                miscompares++;
                $display("FAIL reset.%s: observed %h required %h", e.name, obs, e.val);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_normal();
        rst_n = 1'b1;
        sb_push("imem_addr", 16'h0000); sb_push("dec_nop_n", 16'h0000);
        #1;
        for (int i = 1; i <= 4; i++) begin
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.name); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL normal%0d.%s: observed %h required %h", i, e.name, obs, e.val);
                end
            end
            if (i == 4) break;
            sb_push("imem_addr", 16'(2 * i)); sb_push("ifid_pc2", 16'(2 * i));
            sb_push("ifid_inst", 16'h4000);   sb_push("dec_inst", 16'h4000);
            sb_push("dec_nop_n", 16'h0001);
            tick();
        end
        $display("test_normal done, pc=%h", imem_addr);
    endtask

    task automatic test_stall();
        imem_word = 16'hD8A0;
        sb_push("imem_addr", 16'h0008); sb_push("ifid_inst", 16'hD8A0);
        tick();
        imem_word = 16'h4000;
        send_nop = 1'b0;
        sb_push("dec_inst", 16'h0800); sb_push("dec_nop_n", 16'h0000);
        #1;
        for (int i = 0; i <= 4; i++) begin
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.name); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL stall%0d.%s: observed %h required %h", i, e.name, obs, e.val);
                end
            end
            if (i < 3) begin
                sb_push("imem_addr", 16'h0008); sb_push("ifid_inst", 16'hD8A0);
                sb_push("ifid_pc2", 16'h0008);  sb_push("dec_inst", 16'h0800);
                sb_push("dec_nop_n", 16'h0000); sb_push("stall_cnt", 16'(i + 1));
                tick();
                exp_cnt++;
            end else if (i == 3) begin
                send_nop = 1'b1;
                sb_push("dec_inst", 16'hD8A0); sb_push("dec_nop_n", 16'h0001);
                #1;
            end else begin
                sb_push("imem_addr", 16'h000A); sb_push("ifid_pc2", 16'h000A);
                sb_push("ifid_inst", 16'h4000); sb_push("stall_cnt", 16'h0003);
                tick();
                i = 5;
                while (sb.size() != 0) begin
                    e = sb.pop_front(); obs = observe(e.name); vectors++;
                    if (obs !== e.val) begin
                        miscompares++;
                        $display("FAIL stall_resume.%s: observed %h required %h", e.name, obs, e.val);
                    end
                end
            end
        end
        $display("test_stall done, stall_cnt=%0d", stall_cnt);
    endtask

    task automatic test_flush_stall();
        send_nop = 1'b0; branch_taken = 1'b1; branch_target = 16'h0040;
        sb_push("imem_addr", 16'h0040); sb_push("ifid_inst", 16'h0800);
        sb_push("stall_cnt", 16'(exp_cnt)); sb_push("align_err", 16'h0000);
        tick();
        branch_taken = 1'b0; send_nop = 1'b1;
        #1;
        sb_push("dec_inst", 16'h0800); sb_push("dec_nop_n", 16'h0000);
        while (sb.size() != 0) begin
            e = sb.pop_front(); obs = observe(e.name); vectors++;
            if (obs !== e.val) begin
                miscompares++;
                $display("FAIL flush_stall.%s: observed %h required %h", e.name, obs, e.val);
            end
        end
        $display("test_flush_stall done, pc=%h", imem_addr);
    endtask

    task automatic test_align();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                branch_taken = 1'b1; branch_target = 16'h0041;
                sb_push("imem_addr", 16'h0040); sb_push("align_err", 16'h0001);
            end else begin
                branch_taken = 1'b0;
                sb_push("imem_addr", 16'h0042); sb_push("align_err", 16'h0000);
                sb_push("ifid_inst", 16'h4000);
            end
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.name); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL align%0d.%s: observed %h required %h", i, e.name, obs, e.val);
                end
            end
        end
        $display("test_align done");
    endtask

    task automatic test_halt();
        halt_addr = 16'h0010; halt_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: begin
                    branch_taken = 1'b1; branch_target = 16'h0010;
                    sb_push("imem_addr", 16'h0010); sb_push("halted", 16'h0000);
                end
                1: begin
                    branch_taken = 1'b0;
                    sb_push("ifid_inst", 16'h0000); sb_push("halted", 16'h0001);
                    sb_push("imem_addr", 16'h0010); sb_push("ifid_pc2", 16'h0012);
                    sb_push("dec_nop_n", 16'h0001);
                end
                2: begin
                    sb_push("ifid_inst", 16'h0800); sb_push("halted", 16'h0001);
                    sb_push("imem_addr", 16'h0010); sb_push("dec_nop_n", 16'h0000);
                    sb_push("ifid_pc2", 16'h0012);
                end
                3: begin
                    branch_taken = 1'b1; branch_target = 16'h0020;
                    sb_push("halted", 16'h0000); sb_push("imem_addr", 16'h0020);
                end
                4: begin
                    branch_taken = 1'b0;
                    sb_push("imem_addr", 16'h0022); sb_push("ifid_inst", 16'h4000);
                    sb_push("ifid_pc2", 16'h0022);  sb_push("halted", 16'h0000);
                end
                5: begin
                    branch_taken = 1'b1; branch_target = 16'h0010;
                    sb_push("imem_addr", 16'h0010);
                end
                6: begin
                    // HALT word presented while stalled: the stall wins.
                    branch_taken = 1'b0; send_nop = 1'b0;
                    exp_cnt++;
                    sb_push("halted", 16'h0000); sb_push("imem_addr", 16'h0010);
                    sb_push("ifid_inst", 16'h0800); sb_push("stall_cnt", 16'(exp_cnt));
                end
                default: begin
                    send_nop = 1'b1;
                    sb_push("halted", 16'h0001); sb_push("ifid_inst", 16'h0000);
                    sb_push("imem_addr", 16'h0010);
                end
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.name); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL halt%0d.%s: observed %h required %h", i, e.name, obs, e.val);
                end
            end
        end
        halt_en = 1'b0;
        $display("test_halt done");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                branch_taken = 1'b1; branch_target = 16'hFFFE;
                sb_push("imem_addr", 16'hFFFE); sb_push("halted", 16'h0000);
            end else begin
                branch_taken = 1'b0;
                sb_push("imem_addr", 16'h0000); sb_push("ifid_pc2", 16'h0000);
                sb_push("ifid_inst", 16'h4000);
            end
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.name); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL wrap%0d.%s: observed %h required %h", i, e.name, obs, e.val);
                end
            end
        end
        $display("test_wrap done");
    endtask

    task automatic test_saturate();
        send_nop = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp_cnt++;
            sb_push("stall_cnt", 16'(exp_cnt));
            sb_push("sat_cnt", (exp_cnt > 7) ? 16'd7 : 16'(exp_cnt));
            sb_push("imem_addr", 16'h0000);
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.name); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL saturate%0d.%s: observed %h required %h", i, e.name, obs, e.val);
                end
            end
        end
        send_nop = 1'b1;
        $display("test_saturate done, stall_cnt=%0d sat_cnt=%0d", stall_cnt, sat_cnt);
    endtask

    task automatic test_reset_stall();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    branch_taken = 1'b1; branch_target = 16'h0031;
                    sb_push("imem_addr", 16'h0030); sb_push("align_err", 16'h0001);
                end
                1: begin
                    branch_taken = 1'b0;
                    sb_push("imem_addr", 16'h0032); sb_push("ifid_pc2", 16'h0032);
                end
                2: begin
                    rst_n = 1'b0; send_nop = 1'b0;
                    sb_push("imem_addr", 16'h0000); sb_push("ifid_inst", 16'h0800);
                    sb_push("ifid_pc2", 16'h0000);  sb_push("dec_inst", 16'h0800);
                    sb_push("dec_nop_n", 16'h0000); sb_push("halted", 16'h0000);
                    sb_push("align_err", 16'h0000); sb_push("stall_cnt", 16'h0000);
                    sb_push("sat_cnt", 16'h0000);
                end
                default: begin
                    rst_n = 1'b1; send_nop = 1'b1;
                    sb_push("imem_addr", 16'h0002); sb_push("dec_nop_n", 16'h0001);
                end
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); obs = observe(e.name); vectors++;
                if (obs !== e.val) begin
                    miscompares++;
                    $display("FAIL reset_stall%0d.%s: observed %h required %h", i, e.name, obs, e.val);
                end
            end
        end
        $display("test_reset_stall done");
    endtask

    initial begin
        vectors = 0; miscompares = 0; exp_cnt = 0;
        rst_n = 1'b0; send_nop = 1'b1; branch_taken = 1'b0; branch_target = 16'h0000;
        imem_word = 16'h4000; halt_en = 1'b0; halt_addr = 16'h0000;
        @(negedge clk);
        test_reset();
        test_normal();
        test_stall();
        test_flush_stall();
        test_align();
        test_halt();
        test_wrap();
        test_saturate();
        test_reset_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
